// File: rtl/rvga_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter.
// Word type, arbiter FSM states and grant selector.
package rvga_mem_arbiter_pkg;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DRAIN
    } rvga_arb_state_e;

    typedef enum logic {
        ARB_IMEM,
        ARB_DMEM
    } rvga_arb_sel_e;

endpackage

// File: rtl/rvga_rr_arbiter2.sv
// Two-way grant selector: combinational grant, registered last grant.
// Ports: imem/dmem requests, update strobe, grant valid and selector.
module rvga_rr_arbiter2
    import rvga_mem_arbiter_pkg::*;
#(
    parameter bit rr_en_p = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          imem_req_i,
    input  logic          dmem_req_i,
    input  logic          update_i,
    output logic          gnt_v_o,
    output rvga_arb_sel_e gnt_sel_o
);

    rvga_arb_sel_e last_q;

    always_comb begin
        gnt_v_o   = imem_req_i | dmem_req_i;
        gnt_sel_o = ARB_IMEM;
        if (imem_req_i && dmem_req_i) begin
            if (rr_en_p) begin
                gnt_sel_o = (last_q == ARB_IMEM) ? ARB_DMEM : ARB_IMEM;
            end else begin
                gnt_sel_o = ARB_DMEM;
            end
        end else if (dmem_req_i) begin
            gnt_sel_o = ARB_DMEM;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= ARB_IMEM;
        end else if (update_i && gnt_v_o) begin
            last_q <= gnt_sel_o;
        end
    end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Ports: imem_* fetch side, dmem_* data side, mem_* memory, timeout_o.
module rvga_mem_arbiter
    import rvga_mem_arbiter_pkg::*;
#(
    parameter bit          rr_en_p   = 1'b1,
    parameter int unsigned timeout_p = 1024
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     imem_r_v_i,
    input  rvga_word imem_addr_i,
    output rvga_word imem_data_o,
    output logic     imem_resp_v_o,
    input  logic     dmem_r_v_i,
    input  logic     dmem_w_v_i,
    input  rvga_word dmem_addr_i,
    input  rvga_word dmem_data_i,
    output rvga_word dmem_data_o,
    output logic     dmem_resp_v_o,
    output logic     mem_r_v_o,
    output logic     mem_w_v_o,
    output rvga_word mem_addr_o,
    output rvga_word mem_data_o,
    input  rvga_word mem_data_i,
    input  logic     mem_resp_v_i,
    output logic     timeout_o
);

    localparam int unsigned CW =
        (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(timeout_p);

    rvga_arb_state_e state_q, state_n;
    logic            mem_r_v_n, mem_w_v_n;
    rvga_word        mem_addr_n, mem_data_n;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_n;
    logic            timeout_n;
    logic            gnt_v;
    rvga_arb_sel_e   gnt_sel;
    logic            dmem_req;

    assign dmem_req = dmem_r_v_i | dmem_w_v_i;

    rvga_rr_arbiter2 #(
        .rr_en_p (rr_en_p)
    ) u_arb (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .imem_req_i (imem_r_v_i),
        .dmem_req_i (dmem_req),
        .update_i   (state_q == IDLE),
        .gnt_v_o    (gnt_v),
        .gnt_sel_o  (gnt_sel)
    );

    // Responses are routed straight through in the response cycle.
    assign imem_resp_v_o = (state_q == BUSY_I) && mem_resp_v_i;
    assign dmem_resp_v_o = (state_q == BUSY_D) && mem_resp_v_i;
    assign imem_data_o   = imem_resp_v_o ? mem_data_i : '0;
    assign dmem_data_o   = dmem_resp_v_o ? mem_data_i : '0;

    always_comb begin
        state_n    = state_q;
        mem_r_v_n  = mem_r_v_o;
        mem_w_v_n  = mem_w_v_o;
        mem_addr_n = mem_addr_o;
        mem_data_n = mem_data_o;
        wait_cnt_n = wait_cnt_q;
        timeout_n  = timeout_o;
        unique case (state_q)
            IDLE: begin
                if (gnt_v) begin
                    wait_cnt_n = '0;
                    if (gnt_sel == ARB_DMEM) begin
                        state_n    = BUSY_D;
                        mem_addr_n = dmem_addr_i;
                        mem_data_n = dmem_data_i;
                        // A simultaneous read and write is a write.
                        mem_w_v_n  = dmem_w_v_i;
                        mem_r_v_n  = !dmem_w_v_i;
                    end else begin
                        state_n    = BUSY_I;
                        mem_addr_n = imem_addr_i;
                        mem_data_n = '0;
                        mem_r_v_n  = 1'b1;
                        mem_w_v_n  = 1'b0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp_v_i) begin
                    state_n   = DRAIN;
                    mem_r_v_n = 1'b0;
                    mem_w_v_n = 1'b0;
                end else if (timeout_p != 0 && wait_cnt_q != TMO) begin
                    wait_cnt_n = wait_cnt_q + 1'b1;
                    if (wait_cnt_n == TMO) begin
                        timeout_n = 1'b1;
                    end
                end
            end
            // One dead cycle so a request still held from the
            // response cycle is not granted a second time.
            DRAIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            mem_r_v_o  <= 1'b0;
            mem_w_v_o  <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            wait_cnt_q <= '0;
            timeout_o  <= 1'b0;
        end else begin
            state_q    <= state_n;
            mem_r_v_o  <= mem_r_v_n;
            mem_w_v_o  <= mem_w_v_n;
            mem_addr_o <= mem_addr_n;
            mem_data_o <= mem_data_n;
            wait_cnt_q <= wait_cnt_n;
            timeout_o  <= timeout_n;
        end
    end

endmodule
